spu_operand_forward: RTL and testbench

Operand forwarding network for the dual-issue SPU execution core. It sits between the register file read ports and the even/odd execution pipes. It replaces stale register-file operand values with results still in flight in either pipe's 7-stage result shift register, so that dependent instructions receive the newest value of every source register.

---
 rtl/spu_operand_forward.sv | 64 ++++++
 tb/tb_spu_operand_forward.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spu_operand_forward.sv
// rtl/spu_operand_forward.sv - dual-pipe operand forwarding network for the SPU execution core
module spu_operand_forward (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:31]           instr_even,
  input  logic [0:31]           instr_odd,
  input  logic [0:127]          ra_even,
  input  logic [0:127]          rb_even,
  input  logic [0:127]          rc_even,
  input  logic [0:127]          ra_odd,
  input  logic [0:127]          rb_odd,
  input  logic [0:127]          rt_st_odd,
  input  logic [6:0][0:127]     fw_even_wb,
  input  logic [6:0][0:127]     fw_odd_wb,
  input  logic [6:0][0:6]       fw_addr_even_wb,
  input  logic [6:0][0:6]       fw_addr_odd_wb,
  input  logic [6:0]            fw_write_even_wb,
  input  logic [6:0]            fw_write_odd_wb,
  output logic [0:127]          ra_even_fwd,
  output logic [0:127]          rb_even_fwd,
  output logic [0:127]          rc_even_fwd,
  output logic [0:127]          ra_odd_fwd,
  output logic [0:127]          rb_odd_fwd,
  output logic [0:127]          rt_st_odd_fwd
);

  logic unused_sigs;
  assign unused_sigs = ^{clk, instr_even[0:10], instr_odd[0:10]};

  // Walk oldest to youngest so later hits override; even is visited after odd
  // within a stage so it wins a same-stage tie.
  function automatic logic [0:127] fwd_sel(
    input logic [0:6]   addr,
    input logic [0:127] rf_val
  );
    logic [0:127] v;
    v = rf_val;
    for (int i = 6; i >= 0; i--) begin
      if (fw_write_odd_wb[i] && (fw_addr_odd_wb[i] == addr))
        v = fw_odd_wb[i];
      if (fw_write_even_wb[i] && (fw_addr_even_wb[i] == addr))
        v = fw_even_wb[i];
    end
    return v;
  endfunction

  always_comb begin
    ra_even_fwd   = ra_even;
    rb_even_fwd   = rb_even;
    rc_even_fwd   = rc_even;
    ra_odd_fwd    = ra_odd;
    rb_odd_fwd    = rb_odd;
    rt_st_odd_fwd = rt_st_odd;
    if (!reset) begin
      ra_even_fwd   = fwd_sel(instr_even[18:24], ra_even);
      rb_even_fwd   = fwd_sel(instr_even[11:17], rb_even);
      rc_even_fwd   = fwd_sel(instr_even[25:31], rc_even);
      ra_odd_fwd    = fwd_sel(instr_odd[18:24],  ra_odd);
      rb_odd_fwd    = fwd_sel(instr_odd[11:17],  rb_odd);
      rt_st_odd_fwd = fwd_sel(instr_odd[25:31],  rt_st_odd);
    end
  end

endmodule

// File: tb/tb_spu_operand_forward.sv
// tb/tb_spu_operand_forward.sv - directed self-checking bench for spu_operand_forward
module tb_spu_operand_forward;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:31]       instr_even, instr_odd;
  logic [0:127]      ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd;
  logic [6:0][0:127] fw_even_wb, fw_odd_wb;
  logic [6:0][0:6]   fw_addr_even_wb, fw_addr_odd_wb;
  logic [6:0]        fw_write_even_wb, fw_write_odd_wb;
  logic [0:127]      ra_even_fwd, rb_even_fwd, rc_even_fwd;
  logic [0:127]      ra_odd_fwd, rb_odd_fwd, rt_st_odd_fwd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spu_operand_forward dut (
    .clk(clk), .reset(reset),
    .instr_even(instr_even), .instr_odd(instr_odd),
    .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
    .ra_odd(ra_odd), .rb_odd(rb_odd), .rt_st_odd(rt_st_odd),
    .fw_even_wb(fw_even_wb), .fw_odd_wb(fw_odd_wb),
    .fw_addr_even_wb(fw_addr_even_wb), .fw_addr_odd_wb(fw_addr_odd_wb),
    .fw_write_even_wb(fw_write_even_wb), .fw_write_odd_wb(fw_write_odd_wb),
    .ra_even_fwd(ra_even_fwd), .rb_even_fwd(rb_even_fwd), .rc_even_fwd(rc_even_fwd),
    .ra_odd_fwd(ra_odd_fwd), .rb_odd_fwd(rb_odd_fwd), .rt_st_odd_fwd(rt_st_odd_fwd)
  );

  function automatic logic [0:127] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_fw();
    fw_even_wb = '0; fw_odd_wb = '0;
    fw_addr_even_wb = '0; fw_addr_odd_wb = '0;
    fw_write_even_wb = '0; fw_write_odd_wb = '0;
  endtask

  task automatic set_instr(input logic [6:0] era, erb, erc, ora, orb, ort);
    instr_even = 32'hFFE0_0000;
    instr_odd  = 32'hFFE0_0000;
    instr_even[18:24] = era; instr_even[11:17] = erb; instr_even[25:31] = erc;
    instr_odd[18:24]  = ora; instr_odd[11:17]  = orb; instr_odd[25:31]  = ort;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ra_even = pat(8'h11); rb_even = pat(8'h12); rc_even = pat(8'h13);
    ra_odd  = pat(8'h21); rb_odd  = pat(8'h22); rt_st_odd = pat(8'h23);
    clear_fw();
    set_instr(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    fw_addr_even_wb[0] = 7'd0; fw_write_even_wb[0] = 1'b1; fw_even_wb[0] = pat(8'hEE);
    settle();
    check("reset_ra_even", ra_even_fwd, pat(8'h11));
    check("reset_rt_st_odd", rt_st_odd_fwd, pat(8'h23));

    // r0 is forwardable once reset drops, for every operand addressing it
    reset = 1'b0;
    settle();
    check("r0_ra_even", ra_even_fwd, pat(8'hEE));
    check("r0_rb_odd", rb_odd_fwd, pat(8'hEE));

    // no match
    clear_fw();
    set_instr(7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10);
    settle();
    check("nomatch_ra_even", ra_even_fwd, pat(8'h11));

    // single even match at stage 3
    fw_addr_even_wb[3] = 7'd5; fw_write_even_wb[3] = 1'b1; fw_even_wb[3] = pat(8'hAA);
    settle();
    check("single_ra_even", ra_even_fwd, pat(8'hAA));
    check("single_rb_even_pass", rb_even_fwd, pat(8'h12));
    check("single_rc_even_pass", rc_even_fwd, pat(8'h13));

    // youngest wins
    clear_fw();
    set_instr(7'd5, 7'd6, 7'd7, 7'd8, 7'd20, 7'd9);
    fw_addr_odd_wb[6]  = 7'd9; fw_write_odd_wb[6]  = 1'b1; fw_odd_wb[6]  = pat(8'h22);
    fw_addr_even_wb[2] = 7'd9; fw_write_even_wb[2] = 1'b1; fw_even_wb[2] = pat(8'h33);
    fw_addr_odd_wb[1]  = 7'd9; fw_write_odd_wb[1]  = 1'b1; fw_odd_wb[1]  = pat(8'h44);
    settle();
    check("youngest_stage1", rt_st_odd_fwd, pat(8'h44));
    fw_write_odd_wb[1] = 1'b0;
    settle();
    check("youngest_stage2", rt_st_odd_fwd, pat(8'h33));
    fw_write_even_wb[2] = 1'b0;
    settle();
    check("oldest_stage6", rt_st_odd_fwd, pat(8'h22));

    // r127 from the oldest odd stage
    clear_fw();
    set_instr(7'd127, 7'd6, 7'd7, 7'd8, 7'd20, 7'd9);
    fw_addr_odd_wb[6] = 7'd127; fw_write_odd_wb[6] = 1'b1; fw_odd_wb[6] = pat(8'h7F);
    settle();
    check("r127_ra_even", ra_even_fwd, pat(8'h7F));

    // same-stage tie: even wins
    clear_fw();
    set_instr(7'd5, 7'd12, 7'd7, 7'd8, 7'd12, 7'd9);
    fw_addr_even_wb[4] = 7'd12; fw_write_even_wb[4] = 1'b1; fw_even_wb[4] = pat(8'h55);
    fw_addr_odd_wb[4]  = 7'd12; fw_write_odd_wb[4]  = 1'b1; fw_odd_wb[4]  = pat(8'h66);
    settle();
    check("tie_rb_even", rb_even_fwd, pat(8'h55));
    check("tie_rb_odd", rb_odd_fwd, pat(8'h55));

    // write-enable gating
    fw_write_even_wb[4] = 1'b0; fw_write_odd_wb[4] = 1'b0;
    settle();
    check("gated_rb_even", rb_even_fwd, pat(8'h12));

    // reset masks a full match, release forwards immediately
    fw_write_even_wb[4] = 1'b1;
    reset = 1'b1;
    settle();
    check("reset_mask_rb_even", rb_even_fwd, pat(8'h12));
    reset = 1'b0;
    #1;
    check("reset_release_rb_even", rb_even_fwd, pat(8'h55));

    // cross-pipe, all six operands at once, with an older decoy for r1
    clear_fw();
    set_instr(7'd1, 7'd2, 7'd3, 7'd3, 7'd2, 7'd1);
    fw_addr_even_wb[0] = 7'd1; fw_write_even_wb[0] = 1'b1; fw_even_wb[0] = pat(8'h01);
    fw_addr_odd_wb[2]  = 7'd2; fw_write_odd_wb[2]  = 1'b1; fw_odd_wb[2]  = pat(8'h02);
    fw_addr_even_wb[5] = 7'd3; fw_write_even_wb[5] = 1'b1; fw_even_wb[5] = pat(8'h03);
    fw_addr_odd_wb[6]  = 7'd1; fw_write_odd_wb[6]  = 1'b1; fw_odd_wb[6]  = pat(8'h0F);
    settle();
    check("cross_ra_even", ra_even_fwd, pat(8'h01));
    check("cross_rb_even", rb_even_fwd, pat(8'h02));
    check("cross_rc_even", rc_even_fwd, pat(8'h03));
    check("cross_ra_odd", ra_odd_fwd, pat(8'h03));
    check("cross_rb_odd", rb_odd_fwd, pat(8'h02));
    check("cross_rt_st_odd", rt_st_odd_fwd, pat(8'h01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
